// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit parallel bus driver: power-up init sequence, E-strobe timing,
// and a one-entry request slot fed by synchronized wr (data) / dr (command) edges.
module lcd_bus_driver #(
  parameter int unsigned T_PWRUP_CYC    = 300000,
  parameter int unsigned T_SETUP_CYC    = 2,
  parameter int unsigned T_EPW_CYC      = 10,
  parameter int unsigned T_HOLD_CYC     = 2,
  parameter int unsigned T_CMD_CYC      = 800,
  parameter int unsigned T_CLR_CYC      = 33000,
  parameter int unsigned T_INIT_GAP_CYC = 82000
) (
  input  logic       clk_20m,
  input  logic       rst,
  input  logic       wr,
  input  logic       dr,
  input  logic [7:0] db,
  input  logic [7:0] direc,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       ready,
  output logic       init_done,
  output logic       err_drop,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    LOAD     = 3'd1,
    SETUP    = 3'd2,
    EHI      = 3'd3,
    HOLD     = 3'd4,
    WAIT     = 3'd5,
    IDLE     = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_lim;
  logic             cnt_done;
  logic [2:0]       init_idx_q, init_idx_d;
  logic             init_done_q, init_done_d;
  logic             err_drop_q, err_drop_d;
  logic             slot_full_q, slot_full_d;
  logic             slot_rs_q, slot_rs_d;
  logic [7:0]       slot_byte_q, slot_byte_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_e_q, lcd_e_d;
  logic             wr_s1_q, wr_s2_q, wr_s3_q;
  logic             dr_s1_q, dr_s2_q, dr_s3_q;
  logic             wr_req, dr_req;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h06;
      default:          init_rom = 8'h01;
    endcase
  endfunction

  assign wr_req = wr_s2_q & ~wr_s3_q;
  assign dr_req = dr_s2_q & ~dr_s3_q;

  // Per-state terminal count; the WAIT length depends on the byte just written.
  always_comb begin
    cnt_lim = CNT_W'(1);
    case (state_q)
      PWR_WAIT: cnt_lim = CNT_W'(T_PWRUP_CYC);
      SETUP:    cnt_lim = CNT_W'(T_SETUP_CYC);
      EHI:      cnt_lim = CNT_W'(T_EPW_CYC);
      HOLD:     cnt_lim = CNT_W'(T_HOLD_CYC);
      WAIT: begin
        if (!init_done_q && (init_idx_q < 3'd3))
          cnt_lim = CNT_W'(T_INIT_GAP_CYC);
        else if (!lcd_rs_q && (lcd_data_q[7:1] == 7'd0))
          cnt_lim = CNT_W'(T_CLR_CYC);
        else
          cnt_lim = CNT_W'(T_CMD_CYC);
      end
      default:  cnt_lim = CNT_W'(1);
    endcase
  end

  assign cnt_done = (cnt_q == (cnt_lim - CNT_W'(1)));

  // Slot: LOAD frees it first, then command is offered before data.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_rs_d   = slot_rs_q;
    slot_byte_d = slot_byte_q;
    err_drop_d  = err_drop_q;
    if ((state_q == LOAD) && init_done_q) slot_full_d = 1'b0;
    if (dr_req) begin
      if (slot_full_d) begin
        err_drop_d = 1'b1;
      end else begin
        slot_full_d = 1'b1;
        slot_rs_d   = 1'b0;
        slot_byte_d = direc;
      end
    end
    if (wr_req) begin
      if (slot_full_d) begin
        err_drop_d = 1'b1;
      end else begin
        slot_full_d = 1'b1;
        slot_rs_d   = 1'b1;
        slot_byte_d = db;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    case (state_q)
      PWR_WAIT: if (cnt_done) begin
        state_d    = LOAD;
        init_idx_d = 3'd0;
      end
      LOAD: begin
        if (!init_done_q) begin
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_rom(init_idx_q);
        end else begin
          lcd_rs_d   = slot_rs_q;
          lcd_data_d = slot_byte_q;
        end
        state_d = SETUP;
      end
      SETUP: if (cnt_done) state_d = EHI;
      EHI:   if (cnt_done) state_d = HOLD;
      HOLD:  if (cnt_done) state_d = WAIT;
      WAIT: if (cnt_done) begin
        if (init_done_q) begin
          state_d = IDLE;
        end else if (init_idx_q == 3'd5) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          init_idx_d = init_idx_q + 3'd1;
          state_d    = LOAD;
        end
      end
      IDLE:    if (slot_full_d) state_d = LOAD;
      default: state_d = PWR_WAIT;
    endcase
    lcd_e_d = (state_d == EHI);
    cnt_d   = (state_d != state_q) ? '0 : (cnt_done ? cnt_q : cnt_q + CNT_W'(1));
  end

  always_ff @(posedge clk_20m) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
      err_drop_q  <= 1'b0;
      slot_full_q <= 1'b0;
      slot_rs_q   <= 1'b0;
      slot_byte_q <= 8'h00;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      lcd_e_q     <= 1'b0;
      wr_s1_q     <= 1'b0;
      wr_s2_q     <= 1'b0;
      wr_s3_q     <= 1'b0;
      dr_s1_q     <= 1'b0;
      dr_s2_q     <= 1'b0;
      dr_s3_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      err_drop_q  <= err_drop_d;
      slot_full_q <= slot_full_d;
      slot_rs_q   <= slot_rs_d;
      slot_byte_q <= slot_byte_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      lcd_e_q     <= lcd_e_d;
      wr_s1_q     <= wr;
      wr_s2_q     <= wr_s1_q;
      wr_s3_q     <= wr_s2_q;
      dr_s1_q     <= dr;
      dr_s2_q     <= dr_s1_q;
      dr_s3_q     <= dr_s2_q;
    end
  end

  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_data  = lcd_data_q;
  assign init_done = init_done_q;
  assign err_drop  = err_drop_q;
  assign ready     = init_done_q & (state_q == IDLE) & ~slot_full_q;
  assign dbg_state = state_q;

endmodule
